// File: rtl/sram_to_sram_reader.sv
// Streams len words from two SRAM banks to the calc unit; m_valid trails each address by RD_LATENCY+1 cycles.
// No backpressure: the consumer always accepts, and cke=0 freezes the whole pipeline including the SRAM.
module sram_to_sram_reader #(
  parameter int  DATA_BITS  = 8,
  parameter type data_t     = logic signed [DATA_BITS-1:0],
  parameter int  UNIT_LEN   = 64,
  parameter int  ADDR_BITS  = 10,
  parameter int  RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_re,
  output logic [ADDR_BITS-1:0]  sram_addr,
  input  data_t [UNIT_LEN-1:0]  sram_rdata0,
  input  data_t [UNIT_LEN-1:0]  sram_rdata1,
  output data_t [UNIT_LEN-1:0]  m_data0,
  output data_t [UNIT_LEN-1:0]  m_data1,
  output logic                  m_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [ADDR_BITS-1:0]   len_q;
  logic [RD_LATENCY:0]    vld_sr;
  logic [RD_LATENCY-1:0]  last_mask;
  logic                   last_in_flight;

  assign busy    = (state != IDLE);
  assign m_valid = vld_sr[RD_LATENCY];

  // The final word is one stage from the output when it is the only read still in flight.
  always_comb begin
    last_mask                 = '0;
    last_mask[RD_LATENCY-1]   = 1'b1;
    last_in_flight            = (vld_sr[RD_LATENCY-1:0] == last_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      sram_re   <= 1'b0;
      sram_addr <= '0;
      len_q     <= '0;
      vld_sr    <= '0;
    end else if (cke) begin
      vld_sr <= {vld_sr[RD_LATENCY-1:0], sram_re};
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            len_q     <= len;
            state     <= RUN;
            sram_re   <= 1'b1;
            sram_addr <= '0;
          end
        end
        RUN: begin
          if (sram_addr == len_q - ADDR_BITS'(1)) begin
            state   <= DRAIN;
            sram_re <= 1'b0;
          end else begin
            sram_addr <= sram_addr + ADDR_BITS'(1);
          end
        end
        DRAIN: begin
          if (done) state <= IDLE;
          else      done  <= last_in_flight;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand registers need no reset: their contents only matter while m_valid is high.
  always_ff @(posedge clk) begin
    if (cke && vld_sr[RD_LATENCY-1]) begin
      m_data0 <= sram_rdata0;
      m_data1 <= sram_rdata1;
    end
  end

endmodule
